// File: rtl/ili934x_pkg.sv
// ili934x_pkg
// Shared types for the ILI934x rectangle-fill engine.
//   state_e  : fill engine FSM states
//   mode_e   : pattern modes (value 3 is unnamed and treated as solid)
//   rgb565_t : one RGB565 pixel
//   coord_t  : 16-bit unsigned panel coordinate
//   clip_coord() saturates a coordinate to a maximum value.
package ili934x_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETW   = 2'd1,
    S_START  = 2'd2,
    S_STREAM = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_SOLID     = 2'd0,
    MODE_CHECKER   = 2'd1,
    MODE_ROWSTRIPE = 2'd2
  } mode_e;

  typedef logic [15:0] rgb565_t;
  typedef logic [15:0] coord_t;

  function automatic coord_t clip_coord(input coord_t c, input coord_t limit);
    return (c > limit) ? limit : c;
  endfunction

endpackage

// File: rtl/ili934x_rect_fill_if.sv
// ili934x_rect_fill_if
// Link between the rectangle-fill engine and the low-level ILI934x driver.
//   win_set_stb              : one-cycle strobe, program column/page window
//   win_x0/win_y0/win_x1/win_y1 : window corners (valid from the strobe on)
//   stream_start             : one-cycle strobe, begin memory write
//   pix_data/pix_valid       : pixel stream, held until accepted
//   pix_ready                : driver accepts the pixel on valid&ready
// master = fill engine, slave = driver.
interface ili934x_rect_fill_if import ili934x_pkg::*; ();

  logic    win_set_stb;
  coord_t  win_x0;
  coord_t  win_y0;
  coord_t  win_x1;
  coord_t  win_y1;
  logic    stream_start;
  rgb565_t pix_data;
  logic    pix_valid;
  logic    pix_ready;

  modport master (
    output win_set_stb, win_x0, win_y0, win_x1, win_y1,
    output stream_start, pix_data, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  win_set_stb, win_x0, win_y0, win_x1, win_y1,
    input  stream_start, pix_data, pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/ili934x_pattern_gen.sv
// ili934x_pattern_gen
// Combinational pixel colour for absolute panel position (x, y).
//   x, y     : current pixel coordinate
//   mode     : pattern mode (solid / checker / row stripes, 3 = solid)
//   color_a  : primary colour
//   color_b  : secondary colour
//   data     : resulting RGB565 pixel
// Parameter CHK_LOG2: checker tile edge is 2^CHK_LOG2 pixels.
module ili934x_pattern_gen
  import ili934x_pkg::*;
#(
  parameter int CHK_LOG2 = 3
) (
  input  coord_t     x,
  input  coord_t     y,
  input  logic [1:0] mode,
  input  rgb565_t    color_a,
  input  rgb565_t    color_b,
  output rgb565_t    data
);

  // Only one bit of x and y matters per mode; fold the rest away.
  logic unused_bits;
  assign unused_bits = ^{x, y};

  always_comb begin
    data = color_a;
    case (mode)
      MODE_CHECKER:   data = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? color_b : color_a;
      MODE_ROWSTRIPE: data = y[0] ? color_b : color_a;
      default:        data = color_a;
    endcase
  end

endmodule

// File: rtl/ili934x_rect_fill.sv
// ili934x_rect_fill
// Fills a rectangle on an ILI934x panel: programs the window, starts the
// memory write and streams one pixel per accepted valid/ready beat in
// row-major order.
//   clk, rst_n            : clock, asynchronous active-low reset
//   init_done             : driver initialised, requests allowed
//   req_stb               : request pulse with req_x0/y0/x1/y1, req_mode,
//                           color_a, color_b (all latched at accept)
//   abort                 : cancel the running request
//   busy                  : request in progress
//   done / aborted        : one-cycle completion pulse, aborted qualifies it
//   err                   : one-cycle reject pulse (out-of-range request)
//   drv                   : driver link (window, stream start, pixel stream)
// Build option: define ILI934X_RECT_CLIP_EN to clip out-of-range corners to
// the panel edge instead of rejecting the request.
module ili934x_rect_fill
  import ili934x_pkg::*;
#(
  parameter int X_RES    = 240,
  parameter int Y_RES    = 320,
  parameter int CHK_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       req_stb,
  input  coord_t     req_x0,
  input  coord_t     req_y0,
  input  coord_t     req_x1,
  input  coord_t     req_y1,
  input  logic [1:0] req_mode,
  input  rgb565_t    color_a,
  input  rgb565_t    color_b,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       err,
  ili934x_rect_fill_if.master drv
);

  localparam int     CNT_W = $clog2(X_RES * Y_RES + 1);
  localparam coord_t X_MAX = coord_t'(X_RES - 1);
  localparam coord_t Y_MAX = coord_t'(Y_RES - 1);

  state_e            state, state_d;
  coord_t            win_x0_q, win_y0_q, win_x1_q, win_y1_q;
  coord_t            cur_x, cur_y;
  logic [CNT_W-1:0]  rem_cnt;
  logic [1:0]        mode_q;
  rgb565_t           color_a_q, color_b_q;
  rgb565_t           gen_data;

  coord_t            cx0, cy0, cx1, cy1;
  coord_t            nx0, ny0, nx1, ny1;
  logic              range_bad;
  logic [CNT_W-1:0]  area;

  logic              accept, reject, xfer, last_xfer, done_d, aborted_d;

`ifdef ILI934X_RECT_CLIP_EN
  assign cx0       = clip_coord(req_x0, X_MAX);
  assign cx1       = clip_coord(req_x1, X_MAX);
  assign cy0       = clip_coord(req_y0, Y_MAX);
  assign cy1       = clip_coord(req_y1, Y_MAX);
  assign range_bad = 1'b0;
`else
  assign cx0       = req_x0;
  assign cx1       = req_x1;
  assign cy0       = req_y0;
  assign cy1       = req_y1;
  assign range_bad = (req_x0 > X_MAX) || (req_x1 > X_MAX) ||
                     (req_y0 > Y_MAX) || (req_y1 > Y_MAX);
`endif

  // Corners may arrive in any order; the window is always top-left first.
  assign nx0 = (cx0 <= cx1) ? cx0 : cx1;
  assign nx1 = (cx0 <= cx1) ? cx1 : cx0;
  assign ny0 = (cy0 <= cy1) ? cy0 : cy1;
  assign ny1 = (cy0 <= cy1) ? cy1 : cy0;

  // Corners are in range here, so the pixel count fits CNT_W bits.
  assign area = CNT_W'(nx1 - nx0 + 16'd1) * CNT_W'(ny1 - ny0 + 16'd1);

  // Next-state and pulse decode. A last beat that coincides with abort
  // still counts as a normal completion.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    reject    = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_stb && init_done) begin
          if (range_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_SETW;
          end
        end
      end
      S_SETW:  state_d = abort ? S_IDLE : S_START;
      S_START: state_d = abort ? S_IDLE : S_STREAM;
      S_STREAM: begin
        xfer      = drv.pix_ready;
        last_xfer = drv.pix_ready && (rem_cnt == CNT_W'(1));
        if (last_xfer || abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state != S_IDLE) begin
      done_d    = last_xfer || abort;
      aborted_d = abort && !last_xfer;
    end
  end

  // State register and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      done    <= done_d;
      aborted <= aborted_d;
      err     <= reject;
    end
  end

  // Request latch and pixel walk: x advances first, wrapping to the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x0_q  <= '0;
      win_y0_q  <= '0;
      win_x1_q  <= '0;
      win_y1_q  <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      rem_cnt   <= '0;
      mode_q    <= '0;
      color_a_q <= '0;
      color_b_q <= '0;
    end else if (accept) begin
      win_x0_q  <= nx0;
      win_y0_q  <= ny0;
      win_x1_q  <= nx1;
      win_y1_q  <= ny1;
      cur_x     <= nx0;
      cur_y     <= ny0;
      rem_cnt   <= area;
      mode_q    <= req_mode;
      color_a_q <= color_a;
      color_b_q <= color_b;
    end else if (xfer) begin
      rem_cnt <= rem_cnt - CNT_W'(1);
      if (!last_xfer) begin
        if (cur_x == win_x1_q) begin
          cur_x <= win_x0_q;
          cur_y <= cur_y + 16'd1;
        end else begin
          cur_x <= cur_x + 16'd1;
        end
      end
    end
  end

  ili934x_pattern_gen #(
    .CHK_LOG2 (CHK_LOG2)
  ) u_pattern (
    .x       (cur_x),
    .y       (cur_y),
    .mode    (mode_q),
    .color_a (color_a_q),
    .color_b (color_b_q),
    .data    (gen_data)
  );

  // Strobes and valid decode straight from the state register, so reset
  // drops them without waiting for a clock edge.
  assign busy             = (state != S_IDLE);
  assign drv.win_set_stb  = (state == S_SETW);
  assign drv.stream_start = (state == S_START);
  assign drv.pix_valid    = (state == S_STREAM);
  assign drv.pix_data     = (state == S_STREAM) ? gen_data : '0;
  assign drv.win_x0       = win_x0_q;
  assign drv.win_y0       = win_y0_q;
  assign drv.win_x1       = win_x1_q;
  assign drv.win_y1       = win_y1_q;

endmodule
